// File: rtl/ocd_sram_bist.sv
// March C- BIST controller for NUM_BANKS OCD SRAM macros on a shared bus.
// Banks are tested one at a time in ascending order; the first miscompare aborts the run.
module ocd_sram_bist #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int BANK_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_BANKS-1:0]        bank_en,
    output logic [NUM_BANKS-1:0]        sram_cen,
    output logic                        sram_gwen,
    output logic [DATA_W-1:0]           sram_wen,
    output logic [ADDR_W-1:0]           sram_a,
    output logic [DATA_W-1:0]           sram_d,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_q,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic [BANK_W-1:0]           fail_bank,
    output logic [ADDR_W-1:0]           fail_addr,
    output logic [2:0]                  fail_elem,
    output logic [DATA_W-1:0]           fail_mask
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_SEEK, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                            state_q, state_d;
    logic [NUM_BANKS-1:0]              rem_q, rem_d;
    logic [BANK_W-1:0]                 sel_q, sel_d;
    logic [2:0]                        elem_q, elem_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d;
    logic                              ph_q, ph_d;
    logic [NUM_BANKS-1:0]              cen_q, cen_d;
    logic                              gwen_q, gwen_d;
    logic [DATA_W-1:0]                 wen_q, wen_d;
    logic [ADDR_W-1:0]                 a_q, a_d;
    logic [DATA_W-1:0]                 d_q, d_d;
    logic [1:0]                        vld_pipe_q, vld_pipe_d;
    logic [DATA_W-1:0]                 cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0]                 cmp_addr_q, cmp_addr_d;
    logic [2:0]                        cmp_elem_q, cmp_elem_d;
    logic                              busy_q, busy_d, done_q, done_d;
    logic                              pass_q, pass_d, fail_q, fail_d;
    logic [BANK_W-1:0]                 fail_bank_q, fail_bank_d;
    logic [ADDR_W-1:0]                 fail_addr_q, fail_addr_d;
    logic [2:0]                        fail_elem_q, fail_elem_d;
    logic [DATA_W-1:0]                 fail_mask_q, fail_mask_d;

    logic [NUM_BANKS-1:0][DATA_W-1:0]  q_arr;
    logic [DATA_W-1:0]                 rd_data;
    logic                              miscmp, abort, op_issue, op_wr, last_op, down;
    logic [BANK_W-1:0]                 pick;
    logic [2:0]                        nx_elem;
    logic [ADDR_W-1:0]                 nx_addr;
    logic                              nx_ph;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_q
        assign q_arr[b] = sram_q[b*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        sel_d       = sel_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        ph_d        = ph_q;
        cen_d       = '1;
        gwen_d      = 1'b1;
        wen_d       = '1;
        a_d         = a_q;
        d_d         = d_q;
        vld_pipe_d  = {vld_pipe_q[0], 1'b0};
        // Read background is all-1 in M2/M4, all-0 in M1/M3/M5.
        cmp_exp_d   = {DATA_W{~elem_q[0]}};
        cmp_addr_d  = addr_q;
        cmp_elem_d  = elem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_bank_d = fail_bank_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_mask_d = fail_mask_q;
        abort       = 1'b0;
        op_issue    = 1'b0;
        op_wr       = 1'b0;

        rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (sel_q == BANK_W'(b)) rd_data = q_arr[b];
        miscmp = vld_pipe_q[1] && (rd_data != cmp_exp_q);

        pick = '0;
        for (int b = NUM_BANKS-1; b >= 0; b--)
            if (rem_q[b]) pick = BANK_W'(b);

        down    = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_op = (elem_q == 3'd5) && (addr_q == ADDR_MAX);
        nx_elem = elem_q;
        nx_addr = addr_q;
        nx_ph   = 1'b0;
        if (elem_q != 3'd0 && elem_q != 3'd5 && !ph_q) begin
            nx_ph = 1'b1;
        end else if (down) begin
            if (addr_q == '0) begin
                nx_elem = elem_q + 3'd1;
                nx_addr = (elem_q == 3'd3) ? ADDR_MAX : '0;
            end else begin
                nx_addr = addr_q - ADDR_W'(1);
            end
        end else begin
            if (addr_q == ADDR_MAX) begin
                nx_elem = elem_q + 3'd1;
                nx_addr = (elem_q == 3'd2) ? ADDR_MAX : '0;
            end else begin
                nx_addr = addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    rem_d       = bank_en;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_bank_d = '0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_mask_d = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SEEK;
                end
            end
            S_SEEK: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = ~fail_q;
                end else begin
                    sel_d    = pick;
                    rem_d    = rem_q & ~(NUM_BANKS'(1) << pick);
                    elem_d   = 3'd0;
                    addr_d   = '0;
                    ph_d     = 1'b0;
                    op_issue = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (miscmp) begin
                    abort = 1'b1;
                end else if (last_op) begin
                    state_d = S_FLUSH;
                end else begin
                    elem_d   = nx_elem;
                    addr_d   = nx_addr;
                    ph_d     = nx_ph;
                    op_issue = 1'b1;
                end
            end
            S_FLUSH: begin
                if (miscmp) abort = 1'b1;
                else        state_d = S_SEEK;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            pass_d      = 1'b0;
            fail_d      = 1'b1;
            fail_bank_d = sel_q;
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
            fail_mask_d = rd_data ^ cmp_exp_q;
        end

        // Outputs are registered for the op presented during the coming cycle.
        if (op_issue) begin
            op_wr         = (elem_d == 3'd0) || (elem_d != 3'd5 && ph_d);
            cen_d         = ~(NUM_BANKS'(1) << sel_d);
            gwen_d        = ~op_wr;
            wen_d         = {DATA_W{~op_wr}};
            a_d           = addr_d;
            vld_pipe_d[0] = ~op_wr;
            if (op_wr) d_d = {DATA_W{elem_d[0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            sel_q       <= '0;
            elem_q      <= '0;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            cen_q       <= '1;
            gwen_q      <= 1'b1;
            wen_q       <= '1;
            a_q         <= '0;
            d_q         <= '0;
            vld_pipe_q  <= '0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_bank_q <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            ph_q        <= ph_d;
            cen_q       <= cen_d;
            gwen_q      <= gwen_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            d_q         <= d_d;
            vld_pipe_q  <= vld_pipe_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_bank_q <= fail_bank_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_a    = a_q;
    assign sram_d    = d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_bank = fail_bank_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_mask = fail_mask_q;

endmodule
